// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator for a 4:1 mux: dwell-limited grants with a break-before-make gap.
// Optional macro MUX_SEL_LOCK_EN adds a lock input that holds the current grant past dwell expiry.
module mux_sel_scheduler #(
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] req,
`ifdef MUX_SEL_LOCK_EN
  input  logic       lock,
`endif
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic [3:0] grant,
  output logic       switch_pulse
);

  localparam int unsigned DWELL_W = 8;
  localparam int unsigned GAP_W   = 4;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD   = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam bit                 GAP_EN     = (GAP_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state, w_state;
  logic [1:0]         r_sel, w_sel;
  logic               r_sel_valid, w_sel_valid;
  logic [3:0]         r_grant, w_grant;
  logic               r_switch_pulse, w_switch_pulse;
  logic [1:0]         r_last, w_last;
  logic [DWELL_W-1:0] r_dwell, w_dwell;
  logic [GAP_W-1:0]   r_gap, w_gap;

  logic               w_arb_found;
  logic [1:0]         w_arb_idx;
  logic               w_lock_hold;
  logic               w_release;
  logic               w_try_arb;

`ifdef MUX_SEL_LOCK_EN
  assign w_lock_hold = lock && enable && req[r_sel];
`else
  assign w_lock_hold = 1'b0;
`endif

  // Round-robin search starting after the last winner; lowest offset wins.
  always_comb begin
    logic [1:0] w_cand;
    w_arb_found = |req;
    w_arb_idx   = r_last;
    for (int i = 4; i >= 1; i--) begin
      w_cand = r_last + 2'(i);
      if (req[w_cand]) w_arb_idx = w_cand;
    end
  end

  assign w_release = ((r_dwell == '0) && !w_lock_hold) || !req[r_sel] || !enable;

  // Next-state and registered-output logic.
  always_comb begin
    w_state        = r_state;
    w_sel          = r_sel;
    w_sel_valid    = r_sel_valid;
    w_grant        = r_grant;
    w_switch_pulse = 1'b0;
    w_last         = r_last;
    w_dwell        = r_dwell;
    w_gap          = r_gap;
    w_try_arb      = 1'b0;

    case (r_state)
      ST_IDLE: w_try_arb = 1'b1;
      ST_GRANT: begin
        if (w_release) begin
          if (GAP_EN) begin
            w_sel_valid = 1'b0;
            w_grant     = 4'b0000;
            w_gap       = GAP_LOAD;
            w_state     = ST_GAP;
          end else begin
            w_try_arb = 1'b1;
          end
        end else if (r_dwell != '0) begin
          w_dwell = r_dwell - DWELL_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap == '0) w_try_arb = 1'b1;
        else             w_gap = r_gap - GAP_W'(1);
      end
      default: w_state = ST_IDLE;
    endcase

    // Arbitration point shared by IDLE, gap expiry and zero-gap release.
    if (w_try_arb) begin
      if (enable && w_arb_found) begin
        w_sel          = w_arb_idx;
        w_last         = w_arb_idx;
        w_grant        = 4'b0001 << w_arb_idx;
        w_sel_valid    = 1'b1;
        w_switch_pulse = 1'b1;
        w_dwell        = DWELL_LOAD;
        w_state        = ST_GRANT;
      end else begin
        w_sel_valid = 1'b0;
        w_grant     = 4'b0000;
        w_state     = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_sel          <= 2'd0;
      r_sel_valid    <= 1'b0;
      r_grant        <= 4'b0000;
      r_switch_pulse <= 1'b0;
      r_last         <= 2'd3;
      r_dwell        <= '0;
      r_gap          <= '0;
    end else begin
      r_state        <= w_state;
      r_sel          <= w_sel;
      r_sel_valid    <= w_sel_valid;
      r_grant        <= w_grant;
      r_switch_pulse <= w_switch_pulse;
      r_last         <= w_last;
      r_dwell        <= w_dwell;
      r_gap          <= w_gap;
    end
  end

  assign sel          = r_sel;
  assign sel_valid    = r_sel_valid;
  assign grant        = r_grant;
  assign switch_pulse = r_switch_pulse;

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench: default instance (DWELL=8, GAP=1) and a zero-gap instance (DWELL=3, GAP=0).
// Lock scenario runs only when MUX_SEL_LOCK_EN is defined.
module tb_mux_sel_scheduler;

  logic       clk;
  logic       rst_n;
  logic       a_en, b_en;
  logic [3:0] a_req, b_req;
  logic [1:0] a_sel, b_sel;
  logic       a_valid, b_valid;
  logic [3:0] a_grant, b_grant;
  logic       a_pulse, b_pulse;
`ifdef MUX_SEL_LOCK_EN
  logic       a_lock, b_lock;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mux_sel_scheduler u_a (
    .clk(clk), .rst_n(rst_n), .enable(a_en), .req(a_req),
`ifdef MUX_SEL_LOCK_EN
    .lock(a_lock),
`endif
    .sel(a_sel), .sel_valid(a_valid), .grant(a_grant), .switch_pulse(a_pulse)
  );

  mux_sel_scheduler #(.DWELL_CYCLES(3), .GAP_CYCLES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(b_en), .req(b_req),
`ifdef MUX_SEL_LOCK_EN
    .lock(b_lock),
`endif
    .sel(b_sel), .sel_valid(b_valid), .grant(b_grant), .switch_pulse(b_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] s, input logic v,
                       input logic [3:0] g, input logic p);
    chk({tag, ".sel"},   8'(a_sel),   8'(s));
    chk({tag, ".valid"}, 8'(a_valid), 8'(v));
    chk({tag, ".grant"}, 8'(a_grant), 8'(g));
    chk({tag, ".pulse"}, 8'(a_pulse), 8'(p));
  endtask

  task automatic chk_b(input string tag, input logic [1:0] s, input logic v,
                       input logic [3:0] g, input logic p);
    chk({tag, ".sel"},   8'(b_sel),   8'(s));
    chk({tag, ".valid"}, 8'(b_valid), 8'(v));
    chk({tag, ".grant"}, 8'(b_grant), 8'(g));
    chk({tag, ".pulse"}, 8'(b_pulse), 8'(p));
  endtask

  // sel_valid must equal |grant, and grant must match sel while valid.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("a_inv_valid", 8'(a_valid), 8'(|a_grant));
      if (a_valid) chk("a_inv_onehot", 8'(a_grant), 8'(4'b0001 << a_sel));
      chk("b_inv_valid", 8'(b_valid), 8'(|b_grant));
      if (b_valid) chk("b_inv_onehot", 8'(b_grant), 8'(4'b0001 << b_sel));
    end
  end

  initial begin
    rst_n = 1'b0;
    a_en = 1'b0; a_req = 4'b0000;
    b_en = 1'b0; b_req = 4'b0000;
`ifdef MUX_SEL_LOCK_EN
    a_lock = 1'b0; b_lock = 1'b0;
`endif

    // Reset values
    step(2);
    chk_a("rst_a", 2'd0, 1'b0, 4'b0000, 1'b0);
    chk_b("rst_b", 2'd0, 1'b0, 4'b0000, 1'b0);
    rst_n = 1'b1;

    // Single requester ch0: 8-cycle grant, 1-cycle gap, re-grant
    a_en = 1'b1; a_req = 4'b0001;
    step(1);  chk_a("t1_first", 2'd0, 1'b1, 4'b0001, 1'b1);
    step(1);  chk_a("t1_second", 2'd0, 1'b1, 4'b0001, 1'b0);
    step(6);  chk_a("t1_eighth", 2'd0, 1'b1, 4'b0001, 1'b0);
    step(1);  chk_a("t1_gap", 2'd0, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t1_regrant", 2'd0, 1'b1, 4'b0001, 1'b1);

    // All requesting: round-robin 1,2,3,0 with sel held in gaps
    a_req = 4'b1111;
    step(8);  chk_a("t2_gap0", 2'd0, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t2_ch1", 2'd1, 1'b1, 4'b0010, 1'b1);
    step(8);  chk_a("t2_gap1", 2'd1, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t2_ch2", 2'd2, 1'b1, 4'b0100, 1'b1);
    step(9);  chk_a("t2_ch3", 2'd3, 1'b1, 4'b1000, 1'b1);
    step(9);  chk_a("t2_ch0", 2'd0, 1'b1, 4'b0001, 1'b1);

    // Request drop releases early; next requester after ch2 is ch3
    a_req = 4'b0100;
    step(1);  chk_a("t3_drop0", 2'd0, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t3_ch2", 2'd2, 1'b1, 4'b0100, 1'b1);
    step(3);  a_req = 4'b1001;
    step(1);  chk_a("t3_drop2", 2'd2, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t3_ch3", 2'd3, 1'b1, 4'b1000, 1'b1);

    // Enable drop mid-grant, no grant while disabled, then resume at ch0
    step(2);  a_en = 1'b0;
    step(1);  chk_a("t5_dis", 2'd3, 1'b0, 4'b0000, 1'b0);
    step(3);  chk_a("t5_idle", 2'd3, 1'b0, 4'b0000, 1'b0);
    a_en = 1'b1;
    step(1);  chk_a("t5_resume", 2'd0, 1'b1, 4'b0001, 1'b1);

    // Async reset mid-grant clears outputs without a clock edge
    step(2);
    #2 rst_n = 1'b0;
    #1 chk_a("t5_async", 2'd0, 1'b0, 4'b0000, 1'b0);
    a_req = 4'b0000; a_en = 1'b0;
    step(1);
    rst_n = 1'b1;

    // Zero gap: sel alternates 0,2 with sel_valid held high
    b_en = 1'b1; b_req = 4'b0101;
    step(1);  chk_b("t4_ch0", 2'd0, 1'b1, 4'b0001, 1'b1);
    step(1);  chk_b("t4_hold1", 2'd0, 1'b1, 4'b0001, 1'b0);
    step(1);  chk_b("t4_hold2", 2'd0, 1'b1, 4'b0001, 1'b0);
    step(1);  chk_b("t4_ch2", 2'd2, 1'b1, 4'b0100, 1'b1);
    step(3);  chk_b("t4_ch0b", 2'd0, 1'b1, 4'b0001, 1'b1);
    b_req = 4'b0100;
    step(1);  chk_b("t4_drop", 2'd2, 1'b1, 4'b0100, 1'b1);
    step(2);  chk_b("t4_solo_hold", 2'd2, 1'b1, 4'b0100, 1'b0);
    step(1);  chk_b("t4_solo_regrant", 2'd2, 1'b1, 4'b0100, 1'b1);
    b_en = 1'b0;
    step(1);  chk_b("t4_dis", 2'd2, 1'b0, 4'b0000, 1'b0);

`ifdef MUX_SEL_LOCK_EN
    // Lock extends ch0 past dwell; unlocking releases, then ch1 after the gap
    a_en = 1'b1; a_req = 4'b0011; a_lock = 1'b1;
    step(1);  chk_a("t6_ch0", 2'd0, 1'b1, 4'b0001, 1'b1);
    step(10); chk_a("t6_locked", 2'd0, 1'b1, 4'b0001, 1'b0);
    a_lock = 1'b0;
    step(1);  chk_a("t6_release", 2'd0, 1'b0, 4'b0000, 1'b0);
    step(1);  chk_a("t6_ch1", 2'd1, 1'b1, 4'b0010, 1'b1);
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
